// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for dmem_arbiter: request fields in, grant/response out.
// The master modport is the requester and the slave modport is the arbiter.
interface dmem_arbiter_if #(
  parameter int S = 32,
  parameter int V = 192
);
  logic         req;
  logic         we;
  logic         vec;
  logic [S-1:0] addr;
  logic [V-1:0] wd;
  logic         gnt;
  logic         rvalid;
  logic [V-1:0] rdata;
  logic         err;

  modport master (output req, we, vec, addr, wd, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, vec, addr, wd, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter, one access in flight; gnt at +1, rvalid at +2 (write/err) or +2+RD_LAT (read).
// Requests wait (held by the requester) until granted. Define DMEM_ARB_FIXED_PRIO_EN to make M0 always win a tie.
module dmem_arbiter #(
  parameter int S        = 32,
  parameter int V        = 192,
  parameter int ROM_BASE = 1000,
  parameter int ROM_SIZE = 30000,
  parameter int RAM_BASE = 31000,
  parameter int RAM_SIZE = 30015,
  parameter int RD_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  dmem_arbiter_if.slave      m0,
  dmem_arbiter_if.slave      m1,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic               mem_vec_o,
  output logic               mem_sel_o,
  output logic [S-1:0]       mem_addr_o,
  output logic [V-1:0]       mem_wd_o,
  input  logic [V-1:0]       mem_rd_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [S-1:0] ROM_LO = S'(ROM_BASE);
  localparam logic [S-1:0] ROM_HI = S'(ROM_BASE + ROM_SIZE);
  localparam logic [S-1:0] RAM_LO = S'(RAM_BASE);
  localparam logic [S-1:0] RAM_HI = S'(RAM_BASE + RAM_SIZE);

  state_t          state_q;
  logic            owner_q;
  logic            we_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      gnt_q;
  logic [1:0]      rvalid_q;
  logic [1:0]      rerr_q;
  logic [V-1:0]    rdata_q [2];
  logic            mem_en_q;
  logic            mem_we_q;
  logic            mem_vec_q;
  logic            mem_sel_q;
  logic [S-1:0]    mem_addr_q;
  logic [V-1:0]    mem_wd_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic            last_q;
`endif

  logic            pick;
  logic            sel_we;
  logic            sel_vec;
  logic [S-1:0]    sel_addr;
  logic [V-1:0]    sel_wd;
  logic            rom_hit;
  logic            ram_hit;
  logic [S-1:0]    dec_off;
  logic            dec_err;

  // pick=1 selects M1; the decode runs on the fields about to be latched.
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick = m1.req && !m0.req;
`else
    pick = m1.req && (!m0.req || !last_q);
`endif
    sel_we   = pick ? m1.we   : m0.we;
    sel_vec  = pick ? m1.vec  : m0.vec;
    sel_addr = pick ? m1.addr : m0.addr;
    sel_wd   = pick ? m1.wd   : m0.wd;
    rom_hit  = (sel_addr >= ROM_LO) && (sel_addr < ROM_HI);
    ram_hit  = (sel_addr >= RAM_LO) && (sel_addr < RAM_HI);
    dec_off  = rom_hit ? (sel_addr - ROM_LO) : (ram_hit ? (sel_addr - RAM_LO) : '0);
    dec_err  = !(rom_hit || ram_hit) || (sel_we && rom_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rerr_q     <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_vec_q  <= 1'b0;
      mem_sel_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      // Strobes are single-cycle; the case below raises them for one cycle only.
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rerr_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_vec_q  <= 1'b0;
      mem_sel_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (m0.req || m1.req) begin
            owner_q     <= pick;
            we_q        <= sel_we;
            err_q       <= dec_err;
            gnt_q[pick] <= 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q      <= pick;
`endif
            if (!dec_err) begin
              mem_en_q   <= 1'b1;
              mem_we_q   <= sel_we;
              mem_vec_q  <= sel_vec;
              mem_sel_q  <= ram_hit;
              mem_addr_q <= dec_off;
              mem_wd_q   <= sel_we ? sel_wd : '0;
            end
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (err_q || we_q) begin
            rvalid_q[owner_q] <= 1'b1;
            rerr_q[owner_q]   <= err_q;
            rdata_q[owner_q]  <= '0;
            state_q           <= S_RESP;
          end else begin
            cnt_q   <= CW'(RD_LAT - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q[owner_q]  <= mem_rd_i;
            rvalid_q[owner_q] <= 1'b1;
            state_q           <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m0.gnt     = gnt_q[0];
  assign m1.gnt     = gnt_q[1];
  assign m0.rvalid  = rvalid_q[0];
  assign m1.rvalid  = rvalid_q[1];
  assign m0.err     = rerr_q[0];
  assign m1.err     = rerr_q[1];
  assign m0.rdata   = rdata_q[0];
  assign m1.rdata   = rdata_q[1];
  assign mem_en_o   = mem_en_q;
  assign mem_we_o   = mem_we_q;
  assign mem_vec_o  = mem_vec_q;
  assign mem_sel_o  = mem_sel_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wd_o   = mem_wd_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
